mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, memory address width.
REQ-002 Parameter: DATA_W, default 16, memory data width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N holds a pending access.
REQ-006 reqN_we  input  1  1=write, 0=read.
REQ-007 reqN_addr  input  ADDR_W  access address.
REQ-008 reqN_wdata  input  DATA_W  write data.
REQ-009 reqN_ready  output  1  accept strobe; transfer occurs when valid&&ready in the same cycle.
REQ-010 reqN_rvalid  output  1  one-cycle pulse; reqN_rdata valid.
REQ-011 reqN_rdata  output  DATA_W  read data; holds until the next read response to N.
REQ-012 mem_addr  output  ADDR_W  RAM port address, registered.
REQ-013 mem_we  output  1  RAM write enable, registered.
REQ-014 mem_wdata  output  DATA_W  RAM write data, registered.
REQ-015 mem_rdata  input  DATA_W  RAM read data, synchronous, valid one cycle after address presented.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, READ, RESP.
REQ-017 IDLE: if any valid, reqN_ready SHALL assert combinationally for exactly one winner; addr/we/wdata captured; next ISSUE. No valid: stay IDLE, all ready low.
REQ-018 Winner: single valid wins; both valid -> requester not equal to last_grant wins.
REQ-019 last_grant SHALL update to the winner on every accept.
REQ-020 ready SHALL be low in ISSUE, READ, RESP; at most one reqN_ready high per cycle.
REQ-021 ISSUE: mem_addr/mem_wdata = captured values; mem_we = captured we for exactly one cycle; write -> IDLE; read -> READ.
REQ-022 mem_we SHALL be 0 in every state except ISSUE with captured write; mem_addr/mem_wdata hold last value otherwise.
REQ-023 READ: mem_rdata captured into owner's rdata register; next RESP.
REQ-024 RESP: owner's rvalid high one cycle; other rvalid low; next IDLE.
REQ-025 Latency: accept at T -> write on mem at T+1, next accept possible T+2; read rvalid at T+3, next accept possible T+4.
REQ-026 Starvation bound: a continuously valid requester SHALL be accepted within one other transaction.
REQ-027 Requester inputs changing after accept SHALL not affect the in-flight access.
REQ-028 Same-address write by one requester then read by the other SHALL return the written data (serialised ordering).

Reset
REQ-029 reset high SHALL force, from any state including mid-read: state=IDLE, last_grant=1 (req0 wins first tie), mem_we=0, mem_addr=0, mem_wdata=0, both rvalid=0, both rdata=0, captured regs=0.
REQ-030 An access in flight at reset SHALL be discarded with no rvalid; ready SHALL be low while reset is high.

Structure
REQ-031 Shared package mem_arb_pkg SHALL hold the FSM state encoding and ADDR_W/DATA_W defaults.
REQ-032 Winner selection SHALL be a sub-module rr_pick2 (inputs valid0, valid1, last_grant; outputs grant, grant_id).

Verification
REQ-033 req0 write addr 0x0010 data 0x0001 -> req0_ready at T, mem_we=1 addr 0x0010 wdata 0x0001 at T+1 only.
REQ-034 req0 read addr 0x0010 after REQ-033 (RAM model) -> req0_rvalid at T+3, req0_rdata=0x0001, req1_rvalid stays 0.
REQ-035 Both valid from reset, req0 write 0x0020/0x0003, req1 write 0x0030/0x0004, held -> grants alternate 0,1,0,1.
REQ-036 req1 write 0x0040=0x0005 and req0 read 0x0040 raised same cycle after last_grant=0 -> req1 served first; req0_rdata=0x0005.
REQ-037 reset asserted during READ -> next cycle state IDLE, no rvalid, mem_we=0; first access after release completes normally.
REQ-038 Change req0_addr 0x0050->0x0060 one cycle after accept -> mem_addr=0x0050 at ISSUE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared definitions for the two-requester memory arbiter:
//             FSM state encoding, default bus widths, tie-break helper.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Default memory address / data widths
    localparam int c_ADDR_W_DEFAULT = 16;
    localparam int c_DATA_W_DEFAULT = 16;

    // Requester that last_grant points at after reset, so req0 wins the first tie
    localparam logic c_RESET_LAST_GRANT = 1'b1;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Winner id for two requesters: a lone valid wins outright, a tie goes
    // to the requester that was not granted last time.
    function automatic logic pick_id(input logic v0, input logic v1, input logic last);
        logic id;
        if (v0 && v1) begin
            id = ~last;
        end else begin
            id = v1;
        end
        return id;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Purpose  : Two-way round-robin winner selection. Purely combinational;
//             the caller owns the last_grant register.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic grant_id
);

    // Any valid produces a grant; id resolved by the round-robin helper
    always_comb begin
        grant    = valid0 | valid1;
        grant_id = pick_id(valid0, valid1, last_grant);
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Arbitrates two requesters onto one synchronous single-port RAM.
//             One access in flight at a time: IDLE accepts, ISSUE drives the
//             RAM for one cycle, READ samples RAM data, RESP pulses rvalid.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    logic              r_last_grant;
    logic              r_owner;
    logic              r_cap_we;
    logic [ADDR_W-1:0] r_cap_addr;
    logic [DATA_W-1:0] r_cap_wdata;

    logic              w_grant;
    logic              w_grant_id;
    logic              w_accept;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    rr_pick2 u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_id   (w_grant_id)
    );

    // Accept only in IDLE, and never while reset is asserted
    always_comb begin
        w_accept   = (r_state == IDLE) && w_grant && !reset;
        req0_ready = w_accept && !w_grant_id;
        req1_ready = w_accept &&  w_grant_id;
    end

    // Steer the winning requester's command onto the capture path
    always_comb begin
        w_sel_we    = w_grant_id ? req1_we    : req0_we;
        w_sel_addr  = w_grant_id ? req1_addr  : req0_addr;
        w_sel_wdata = w_grant_id ? req1_wdata : req0_wdata;
    end

    // The capture registers double as the RAM address/data drivers: they are
    // loaded on accept, present the access during ISSUE and hold afterwards.
    always_comb begin
        mem_addr  = r_cap_addr;
        mem_wdata = r_cap_wdata;
    end

    // Latch the winner's command on accept so later input changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_we    <= 1'b0;
            r_cap_addr  <= '0;
            r_cap_wdata <= '0;
            r_owner     <= 1'b0;
        end else if (w_accept) begin
            r_cap_we    <= w_sel_we;
            r_cap_addr  <= w_sel_addr;
            r_cap_wdata <= w_sel_wdata;
            r_owner     <= w_grant_id;
        end
    end

    // Arbiter FSM with registered write-enable and response strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= c_RESET_LAST_GRANT;
            mem_we       <= 1'b0;
            req0_rvalid  <= 1'b0;
            req1_rvalid  <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant_id;
                        mem_we       <= w_sel_we;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Writes finish once the RAM has seen the strobe
                    r_state <= r_cap_we ? IDLE : READ;
                end
                READ: begin
                    // RAM data is valid now; response pulses during RESP
                    req0_rvalid <= !r_owner;
                    req1_rvalid <=  r_owner;
                    r_state     <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Capture RAM read data into the owning requester's holding register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else if (r_state == READ) begin
            if (r_owner) begin
                req1_rdata <= mem_rdata;
            end else begin
                req0_rdata <= mem_rdata;
            end
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter with a synchronous
//             RAM model, a reference memory and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_we, req0_ready, req0_rvalid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_we, req1_ready, req1_rvalid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            gq[$];
    logic [DW-1:0] ram     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: data for the address presented appears next cycle
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_ready  (req0_ready),
        .req0_rvalid (req0_rvalid),
        .req0_rdata  (req0_rdata),
        .req1_valid  (req1_valid),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_ready  (req1_ready),
        .req1_rvalid (req1_rvalid),
        .req1_rdata  (req1_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic drive(input int id, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Returns at the negedge of the accept cycle when ok=1
    task automatic wait_ready(input int id, output int waited, output bit ok);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
            tick();
        end
        check("accept_seen", {31'd0, ok}, 32'd1);
    endtask

    // One full access: accept, ISSUE bus check, and for reads the response
    task automatic access(input int id, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input string tag, output int waited);
        bit   ok;
        exp_t e;
        drive(id, 1'b1, we, addr, wdata);
        wait_ready(id, waited, ok);
        if (!ok) begin
            drive(id, 1'b0, 1'b0, '0, '0);
            tick();
            return;
        end
        check({tag, "_other_ready"}, {31'd0, (id == 0) ? req1_ready : req0_ready}, 32'd0);
        if (we) ref_mem[addr] = wdata;
        else    sb.push_back('{id, ref_mem[addr]});
        tick();
        // Disturb the requester inputs right after accept
        drive(id, 1'b0, ~we, addr + 16'h0010, ~wdata);
        @(negedge clk);
        check({tag, "_issue_we"},   {31'd0, mem_we}, {31'd0, we});
        check({tag, "_issue_addr"}, {16'd0, mem_addr}, {16'd0, addr});
        if (we) check({tag, "_issue_wdata"}, {16'd0, mem_wdata}, {16'd0, wdata});
        tick();
        @(negedge clk);
        if (we) begin
            check({tag, "_we_drop"}, {31'd0, mem_we}, 32'd0);
            tick();
            return;
        end
        check({tag, "_rvalid_early"}, {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
        tick();
        @(negedge clk);
        check({tag, "_rvalid"}, {30'd0, req1_rvalid, req0_rvalid}, (id == 0) ? 32'd1 : 32'd2);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, {16'd0, (e.id == 0) ? req0_rdata : req1_rdata}, {16'd0, e.data});
        end
        tick();
        @(negedge clk);
        check({tag, "_rvalid_pulse"}, {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  waited;
        int  last_cyc;
        int  expg;
        bit  ok;

        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 16'h0011, 16'h0022);
        drive(1, 1'b1, 1'b0, 16'h0033, 16'h0044);
        tick(); tick();
        @(negedge clk);
        check("rst_ready",   {30'd0, req1_ready, req0_ready}, 32'd0);
        check("rst_mem_we",  {31'd0, mem_we}, 32'd0);
        check("rst_addr",    {16'd0, mem_addr}, 32'd0);
        check("rst_wdata",   {16'd0, mem_wdata}, 32'd0);
        check("rst_rvalid",  {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
        check("rst_rdata",   {req1_rdata, req0_rdata}, 32'd0);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();
        reset = 1'b0;
        tick();

        // Single write then read-back by req0
        access(0, 1'b1, 16'h0010, 16'h0001, "w0_10", waited);
        access(0, 1'b0, 16'h0010, 16'h0000, "r0_10", waited);

        // Both held from reset: grants alternate, one accept every two cycles
        do_reset();
        gq = {0, 1, 0, 1};
        last_cyc = 0;
        drive(0, 1'b1, 1'b1, 16'h0020, 16'h0003);
        drive(1, 1'b1, 1'b1, 16'h0030, 16'h0004);
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            check("arb_accept_seen", {31'd0, ok}, 32'd1);
            if (!ok) break;
            check("arb_one_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
            expg = gq.pop_front();
            check("arb_order", {31'd0, req1_ready}, expg);
            if (k > 0) check("arb_spacing", cyc - last_cyc, 32'd2);
            last_cyc = cyc;
            tick();
            @(negedge clk);
            check("arb_mem_we",   {31'd0, mem_we}, 32'd1);
            check("arb_mem_addr", {16'd0, mem_addr}, (expg == 1) ? 32'h30 : 32'h20);
            tick();
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        ref_mem[16'h0020] = 16'h0003;
        ref_mem[16'h0030] = 16'h0004;

        // req0 goes last, then a simultaneous req1 write / req0 read of 0x40
        access(0, 1'b0, 16'h0020, 16'h0000, "r0_20", waited);
        drive(1, 1'b1, 1'b1, 16'h0040, 16'h0005);
        drive(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        @(negedge clk);
        check("tie_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
        ref_mem[16'h0040] = 16'h0005;
        tick();
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("tie_issue_addr", {16'd0, mem_addr}, 32'h40);
        tick();
        access(0, 1'b0, 16'h0040, 16'h0000, "r0_40", waited);
        check("starve_wait", waited, 32'd0);

        // Address change after accept must not leak into the access
        access(0, 1'b1, 16'h0050, 16'h0007, "w0_50", waited);
        access(0, 1'b0, 16'h0050, 16'h0000, "r0_50", waited);

        // Reset in the middle of a read
        access(1, 1'b0, 16'h0020, 16'h0000, "r1_20", waited);
        drive(1, 1'b1, 1'b0, 16'h0030, 16'h0000);
        wait_ready(1, waited, ok);
        tick();
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 16'h0070, 16'h0009);
        #1;
        check("midrd_ready",  {30'd0, req1_ready, req0_ready}, 32'd0);
        check("midrd_we",     {31'd0, mem_we}, 32'd0);
        check("midrd_rvalid", {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
        check("midrd_addr",   {16'd0, mem_addr}, 32'd0);
        check("midrd_rdata",  {req1_rdata, req0_rdata}, 32'd0);
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rvalid", {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
            tick();
        end
        access(1, 1'b0, 16'h0030, 16'h0000, "r1_30", waited);
        check("r0_rdata_hold", {16'd0, req0_rdata}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
